// File: rtl/reflet_mem_bridge.sv
// Bridge between the CPU's reduced-behavior stage and a valid/ready memory port.
// Stalls the CPU for each access and flags a sticky bus error on timeout.
module reflet_mem_bridge #(
    parameter int wordsize = 16,
    parameter int timeout  = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] cpu_addr,
    input  logic [wordsize-1:0] cpu_wdata,
    input  logic                cpu_write_en,
    input  logic                cpu_read_en,
    output logic [wordsize-1:0] cpu_rdata,
    output logic                cpu_enable,
    output logic [wordsize-1:0] mem_addr,
    output logic [wordsize-1:0] mem_wdata,
    output logic                mem_we,
    output logic                mem_valid,
    input  logic                mem_ready,
    input  logic [wordsize-1:0] mem_rdata,
    output logic                bus_error
);

    localparam int cnt_w = (timeout < 1) ? 1 : $clog2(timeout + 1);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'((timeout > 0) ? (timeout - 1) : 0);
    localparam logic [cnt_w-1:0] cnt_max  = {cnt_w{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [wordsize-1:0] mem_addr_r;
    logic [wordsize-1:0] mem_wdata_r;
    logic                mem_we_r;
    logic                mem_valid_r;
    logic [wordsize-1:0] cpu_rdata_r;
    logic [cnt_w-1:0]    wait_cnt_r;
    logic                bus_error_r;
    logic                req_s;
    logic                timeout_hit_s;
    logic                cpu_enable_s;

    assign req_s         = cpu_write_en | cpu_read_en;
    // The counter sits at timeout-1 in the last allowed WAIT cycle; this edge makes it reach timeout.
    assign timeout_hit_s = (timeout > 0) && (wait_cnt_r == cnt_last);

    // CPU advance strobe: must drop in the same IDLE cycle a request appears.
    always_comb begin
        cpu_enable_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    cpu_enable_s = 1'b0;
                end else begin
                    cpu_enable_s = 1'b1;
                end
            end
            WAIT:    cpu_enable_s = 1'b0;
            DONE:    cpu_enable_s = 1'b1;
            default: cpu_enable_s = 1'b0;
        endcase
    end

    // Access sequencing, memory request registers, read capture and timeout tracking.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            mem_addr_r  <= {wordsize{1'b0}};
            mem_wdata_r <= {wordsize{1'b0}};
            mem_we_r    <= 1'b0;
            mem_valid_r <= 1'b0;
            cpu_rdata_r <= {wordsize{1'b0}};
            wait_cnt_r  <= {cnt_w{1'b0}};
            bus_error_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        mem_addr_r  <= cpu_addr;
                        mem_wdata_r <= cpu_wdata;
                        mem_we_r    <= cpu_write_en;
                        mem_valid_r <= 1'b1;
                        wait_cnt_r  <= {cnt_w{1'b0}};
                        state_r     <= WAIT;
                    end else begin
                        mem_valid_r <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        if (!mem_we_r) begin
                            cpu_rdata_r <= mem_rdata;
                        end
                        mem_valid_r <= 1'b0;
                        state_r     <= DONE;
                    end else if (timeout_hit_s) begin
                        if (!mem_we_r) begin
                            cpu_rdata_r <= {wordsize{1'b0}};
                        end
                        wait_cnt_r  <= wait_cnt_r + cnt_w'(1);
                        bus_error_r <= 1'b1;
                        mem_valid_r <= 1'b0;
                        state_r     <= DONE;
                    end else if (wait_cnt_r != cnt_max) begin
                        wait_cnt_r  <= wait_cnt_r + cnt_w'(1);
                    end else begin
                        wait_cnt_r  <= wait_cnt_r;
                    end
                end
                DONE: begin
                    mem_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    mem_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign cpu_enable = cpu_enable_s;
    assign cpu_rdata  = cpu_rdata_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_we     = mem_we_r;
    assign mem_valid  = mem_valid_r;
    assign bus_error  = bus_error_r;

endmodule
